uart_alu_tx_framer: RTL and testbench

- Host-side packet framer: the transmit-direction counterpart of the UART ALU command parser.
- Builds a command frame in this byte order: opcode, reserved byte, length LSB, length MSB, then payload bytes.
- Input is one command descriptor plus a payload byte stream. Output is a byte stream to the UART transmitter over valid/ready.
- Used by the loopback testbench host model and by the on-chip self-test initiator.

---
 rtl/uart_alu_pkg.sv | 32 +++
 rtl/uart_byte_slot.sv | 52 +++++
 rtl/uart_alu_tx_framer.sv | 131 +++++++++++++
 tb/tb_uart_alu_tx_framer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU command path (receiver parser and
// transmit-side framer): opcodes, frame header geometry and framer states.
package uart_alu_pkg;

    // Opcode understood by the receiver: echo the payload back.
    localparam logic [7:0] OP_ECHO = 8'hEC;

    // Every frame starts with opcode, reserved byte, length LSB, length MSB.
    localparam int HEADER_BYTES = 4;

    // Framer states, each named for the next byte to be loaded into the slot.
    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_RSVD    = 3'd1,
        TX_LENL    = 3'd2,
        TX_LENM    = 3'd3,
        TX_PAYLOAD = 3'd4
    } tx_state_e;

    // Number of payload bytes carried by a frame whose total length is len.
    // Lengths shorter than the header are legal and carry no payload.
    function automatic logic [15:0] payload_count(input logic [15:0] len);
        logic [15:0] cnt;
        if (len > 16'(HEADER_BYTES)) begin
            cnt = len - 16'(HEADER_BYTES);
        end else begin
            cnt = 16'h0000;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/uart_byte_slot.sv
// One-entry valid/ready output register. The owner loads a byte only when
// free_o is high; valid_o/data_o come straight from flops and data_o is held
// stable while the downstream stalls.
module uart_byte_slot (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       free_o
);

    logic       valid_d, valid_q;
    logic [7:0] data_d,  data_q;

    // Slot can take a new byte when empty or when its byte leaves this cycle.
    always_comb begin
        free_o = !valid_q || ready_i;
    end

    // Next slot contents: load wins, otherwise drain on ready, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/uart_alu_tx_framer.sv
// Transmit-side frame builder: turns one command descriptor plus a payload
// byte stream into opcode, reserved, len LSB, len MSB, payload... on a
// valid/ready byte stream towards the UART transmitter.
module uart_alu_tx_framer
    import uart_alu_pkg::*;
#(
    parameter logic [7:0] RESERVED_BYTE = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        cmd_valid_i,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [15:0] cmd_len_i,
    output logic        cmd_ready_o,
    input  logic        pl_valid_i,
    input  logic [7:0]  pl_data_i,
    output logic        pl_ready_o,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [7:0]  data_o,
    output logic        busy_o
);

    tx_state_e   state_d, state_q;
    logic [15:0] len_d,   len_q;
    logic [15:0] cnt_d,   cnt_q;
    logic        slot_free_s;
    logic        load_s;
    logic [7:0]  load_data_s;
    logic        cmd_fire_s;
    logic        pl_fire_s;

    uart_byte_slot u_slot (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .load_i      (load_s),
        .load_data_i (load_data_s),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .free_o      (slot_free_s)
    );

    // Handshake outputs and busy flag; ready only in the state that consumes
    // that input, and never while reset is being applied.
    always_comb begin
        cmd_ready_o = reset_ni && (state_q == TX_IDLE) && slot_free_s;
        pl_ready_o  = reset_ni && (state_q == TX_PAYLOAD) && slot_free_s;
        busy_o      = (state_q != TX_IDLE) || valid_o;
        cmd_fire_s  = cmd_valid_i && cmd_ready_o;
        pl_fire_s   = pl_valid_i && pl_ready_o;
    end

    // Next-state logic: pick the byte to load and advance through the frame.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        load_s      = 1'b0;
        load_data_s = 8'h00;
        case (state_q)
            TX_IDLE: begin
                if (cmd_fire_s) begin
                    load_s      = 1'b1;
                    load_data_s = cmd_opcode_i;
                    len_d       = cmd_len_i;
                    cnt_d       = payload_count(cmd_len_i);
                    state_d     = TX_RSVD;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_RSVD: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = RESERVED_BYTE;
                    state_d     = TX_LENL;
                end else begin
                    state_d = TX_RSVD;
                end
            end
            TX_LENL: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = len_q[7:0];
                    state_d     = TX_LENM;
                end else begin
                    state_d = TX_LENL;
                end
            end
            TX_LENM: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = len_q[15:8];
                    state_d     = (cnt_q != 16'h0000) ? TX_PAYLOAD : TX_IDLE;
                end else begin
                    state_d = TX_LENM;
                end
            end
            TX_PAYLOAD: begin
                // Leaving at count 1 means the counter never wraps below zero.
                if (pl_fire_s) begin
                    load_s      = 1'b1;
                    load_data_s = pl_data_i;
                    cnt_d       = cnt_q - 16'd1;
                    state_d     = (cnt_q == 16'd1) ? TX_IDLE : TX_PAYLOAD;
                end else begin
                    state_d = TX_PAYLOAD;
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = 16'h0000;
            end
        endcase
    end

    // State, latched length and remaining-payload counter registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= TX_IDLE;
            len_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_tx_framer.sv
// Self-checking bench for uart_alu_tx_framer: frames are described at the
// byte-list level and every handed-off output byte is compared in order.
module tb_uart_alu_tx_framer;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        cmd_valid_i;
    logic [7:0]  cmd_opcode_i;
    logic [15:0] cmd_len_i;
    logic        cmd_ready_o;
    logic        pl_valid_i;
    logic [7:0]  pl_data_i;
    logic        pl_ready_o;
    logic        ready_i;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        busy_o;

    uart_alu_tx_framer dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_ready_o  (cmd_ready_o),
        .pl_valid_i   (pl_valid_i),
        .pl_data_i    (pl_data_i),
        .pl_ready_o   (pl_ready_o),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending descriptors, payload source, expected bytes.
    logic [7:0]  cop_q[$];
    logic [15:0] clen_q[$];
    logic [7:0]  pl_q[$];
    logic [7:0]  exp_q[$];
    int          acc_cyc_q[$];
    int          plhs_cyc_q[$];
    int          hand_cyc_q[$];
    int          plr_cycles;
    int          vlow_busy;
    int          rdy_pct  = 100;
    int          gap_mode = 0;
    bit          stall_en = 1'b0;
    logic [7:0]  stall_byte = 8'h00;
    int          stall_len = 0;

    function automatic int pl_count(input logic [15:0] len);
        if (int'(len) > 4) return int'(len) - 4;
        else return 0;
    endfunction

    task automatic add_frame(input logic [7:0] op, input logic [15:0] len,
                             input bit rnd, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b;
        cop_q.push_back(op);
        clen_q.push_back(len);
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(len[7:0]);
        exp_q.push_back(len[15:8]);
        for (int i = 0; i < pl_count(len); i++) begin
            if (rnd) b = 8'($urandom);
            else b = 8'(base + 8'(i) * step);
            exp_q.push_back(b);
            pl_q.push_back(b);
        end
    endtask

    task automatic run_engine(input int max_cyc);
        int c = 0;
        int owed = 0;
        int pl_owed = 0;
        int stall_cnt = 0;
        bit stalled_now;
        bit have_prev = 1'b0;
        logic pv, pr;
        logic [7:0] pdata, e;
        acc_cyc_q.delete();
        plhs_cyc_q.delete();
        hand_cyc_q.delete();
        plr_cycles = 0;
        vlow_busy = 0;
        pv = 1'b0; pr = 1'b0; pdata = 8'h00;
        while ((exp_q.size() != 0 || clen_q.size() != 0) && c < max_cyc) begin
            @(negedge clk_i);
            if (clen_q.size() != 0) begin
                cmd_valid_i = 1'b1;
                cmd_opcode_i = cop_q[0];
                cmd_len_i = clen_q[0];
            end else begin
                cmd_valid_i = 1'b0;
                cmd_opcode_i = 8'($urandom);
                cmd_len_i = 16'($urandom);
            end
            if (pl_q.size() != 0 &&
                !(gap_mode == 1 && (c % 3) == 1) &&
                !(gap_mode == 2 && $urandom_range(99) < 30)) begin
                pl_valid_i = 1'b1;
                pl_data_i = pl_q[0];
            end else begin
                pl_valid_i = 1'b0;
                pl_data_i = 8'($urandom);
            end
            stalled_now = 1'b0;
            if (stall_en && stall_cnt < stall_len && valid_o === 1'b1 && data_o === stall_byte) begin
                ready_i = 1'b0;
                stall_cnt++;
                stalled_now = 1'b1;
            end else begin
                ready_i = ($urandom_range(99) < rdy_pct);
            end
            #1;
            n_tests++;
            if (busy_o !== (owed != 0)) begin
                n_fail++;
                $display("FAIL busy: cycle %0d got %b expected %b", c, busy_o, (owed != 0));
            end
            n_tests++;
            if (pl_ready_o === 1'b1 && pl_owed == 0) begin
                n_fail++;
                $display("FAIL pl_ready_no_payload: cycle %0d got 1 expected 0", c);
            end
            if (have_prev && pv && !pr) begin
                n_tests++;
                if (valid_o !== 1'b1 || data_o !== pdata) begin
                    n_fail++;
                    $display("FAIL hold: cycle %0d got v=%b d=%02h expected v=1 d=%02h",
                             c, valid_o, data_o, pdata);
                end
            end
            if (stalled_now) begin
                n_tests++;
                if (pl_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_pl_ready: cycle %0d got %b expected 0", c, pl_ready_o);
                end
            end
            if (pl_ready_o === 1'b1) plr_cycles++;
            if (valid_o !== 1'b1 && owed != 0) vlow_busy++;
            if (cmd_valid_i && cmd_ready_o === 1'b1) begin
                owed += 4 + pl_count(clen_q[0]);
                pl_owed += pl_count(clen_q[0]);
                acc_cyc_q.push_back(c);
                void'(cop_q.pop_front());
                void'(clen_q.pop_front());
            end
            if (pl_valid_i && pl_ready_o === 1'b1) begin
                void'(pl_q.pop_front());
                pl_owed--;
                plhs_cyc_q.push_back(c);
            end
            if (valid_o === 1'b1 && ready_i) begin
                hand_cyc_q.push_back(c);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_byte: cycle %0d got %02h expected none", c, data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin
                        n_fail++;
                        $display("FAIL byte: cycle %0d got %02h expected %02h", c, data_o, e);
                    end
                end
                if (owed > 0) owed--;
            end
            pv = valid_o; pr = ready_i; pdata = data_o; have_prev = 1'b1;
            c++;
        end
        if (c >= max_cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d bytes outstanding expected 0", exp_q.size());
            exp_q.delete(); pl_q.delete(); cop_q.delete(); clen_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        pl_valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        n_tests++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || pl_ready_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: got busy=%b v=%b plr=%b cr=%b expected 0 0 0 1",
                     name, busy_o, valid_o, pl_ready_o, cmd_ready_o);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_opcode_i = 8'h55;
        cmd_len_i = 16'd9;
        pl_valid_i = 1'b1;
        pl_data_i = 8'h33;
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || cmd_ready_o !== 1'b0 ||
            pl_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got v=%b d=%02h cr=%b plr=%b busy=%b expected all 0",
                     valid_o, data_o, cmd_ready_o, pl_ready_o, busy_o);
        end
        @(negedge clk_i);
        reset_ni = 1'b1;
        cmd_valid_i = 1'b0;
        pl_valid_i = 1'b0;
        #1;
        n_tests++;
        if (cmd_ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got cr=%b v=%b expected 1 0", cmd_ready_o, valid_o);
        end
    endtask

    task automatic test_frame_payload();
        rdy_pct = 100; gap_mode = 0;
        add_frame(8'hEC, 16'd6, 1'b0, 8'hAA, 8'h11);
        run_engine(100);
        check_int("frame_bytes", hand_cyc_q.size(), 6);
        if (hand_cyc_q.size() == 6) begin
            check_int("frame_span", hand_cyc_q[5] - hand_cyc_q[0], 5);
            check_int("frame_latency", hand_cyc_q[0] - acc_cyc_q[0], 1);
        end
        check_idle("frame");
    endtask

    task automatic test_stall();
        rdy_pct = 100; gap_mode = 0;
        stall_en = 1'b1; stall_byte = 8'h06; stall_len = 3;
        add_frame(8'hEC, 16'd6, 1'b0, 8'hAA, 8'h11);
        run_engine(100);
        stall_en = 1'b0;
        check_int("stall_bytes", hand_cyc_q.size(), 6);
        if (hand_cyc_q.size() == 6) check_int("stall_span", hand_cyc_q[5] - hand_cyc_q[0], 8);
        check_idle("stall");
    endtask

    task automatic test_header_only();
        rdy_pct = 100; gap_mode = 0;
        add_frame(8'hEC, 16'd4, 1'b0, 8'h00, 8'h00);
        add_frame(8'hEC, 16'd2, 1'b0, 8'h00, 8'h00);
        run_engine(100);
        check_int("hdr_bytes", hand_cyc_q.size(), 8);
        check_int("hdr_pl_ready", plr_cycles, 0);
        check_idle("hdr");
    endtask

    task automatic test_large();
        rdy_pct = 100; gap_mode = 0;
        add_frame(8'h12, 16'h0104, 1'b0, 8'h00, 8'h01);
        run_engine(2000);
        check_int("large_bytes", hand_cyc_q.size(), 260);
        check_int("large_pl_hs", plhs_cyc_q.size(), 256);
        check_idle("large");
    endtask

    task automatic test_back_to_back();
        rdy_pct = 100; gap_mode = 1;
        add_frame(8'hEC, 16'd10, 1'b1, 8'h00, 8'h00);
        add_frame(8'h5A, 16'd7, 1'b1, 8'h00, 8'h00);
        run_engine(300);
        gap_mode = 0;
        check_int("b2b_bytes", hand_cyc_q.size(), 17);
        if (acc_cyc_q.size() == 2 && plhs_cyc_q.size() == 9)
            check_int("b2b_accept", acc_cyc_q[1], plhs_cyc_q[5] + 1);
        else
            check_int("b2b_handshakes", acc_cyc_q.size() * 100 + plhs_cyc_q.size(), 209);
        n_tests++;
        if (vlow_busy == 0) begin
            n_fail++;
            $display("FAIL starve_gap: got %0d low cycles expected >0", vlow_busy);
        end
        check_idle("b2b");
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq [4];
        seq[0] = 8'hEC; seq[1] = 8'h00; seq[2] = 8'h06; seq[3] = 8'h00;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_opcode_i = 8'hEC; cmd_len_i = 16'd6;
        pl_valid_i = 1'b0; ready_i = 1'b1;
        #1;
        check_int("mid_cmd_ready", int'(cmd_ready_o), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            #1;
            n_tests++;
            if (valid_o !== 1'b1 || data_o !== seq[k]) begin
                n_fail++;
                $display("FAIL mid_hdr%0d: got v=%b d=%02h expected v=1 d=%02h",
                         k, valid_o, data_o, seq[k]);
            end
        end
        reset_ni = 1'b0;
        @(negedge clk_i);
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b busy=%b expected 0 0", valid_o, busy_o);
        end
        reset_ni = 1'b1;
        add_frame(8'hEC, 16'd5, 1'b0, 8'h7F, 8'h00);
        run_engine(100);
        check_int("mid_new_bytes", hand_cyc_q.size(), 5);
        check_idle("mid");
    endtask

    task automatic test_random();
        int total = 0;
        int len;
        rdy_pct = 70; gap_mode = 2;
        for (int f = 0; f < 20; f++) begin
            len = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : int'($urandom_range(14));
            add_frame(8'($urandom), 16'(len), 1'b1, 8'h00, 8'h00);
            total += 4 + pl_count(16'(len));
        end
        run_engine(20000);
        rdy_pct = 100; gap_mode = 0;
        check_int("rand_bytes", hand_cyc_q.size(), total);
        check_idle("rand");
    endtask

    initial begin
        test_reset();
        test_frame_payload();
        test_stall();
        test_header_only();
        test_large();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
